sat_add_arbiter: RTL and testbench
==================================

SAT_ADD_ARBITER -- requirements
Module: sat_add_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width, two's complement, signed.
REQ-002 Parameter NREQ, default 4: number of requesters (LSTM gate lanes i, f, g, o).
REQ-003 Parameter IDW, default 2: requester-ID width; SHALL equal clog2(NREQ).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  NREQ  per-requester operand-pair valid.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a  input  NREQ*WIDTH  operand A; lane k at bits [k*WIDTH +: WIDTH].
REQ-009 req_b  input  NREQ*WIDTH  operand B; same packing.
REQ-010 rsp_valid  output  1  result register holds a valid result.
REQ-011 rsp_ready  input  1  downstream accepts result.
REQ-012 rsp_data  output  WIDTH  saturated sum.
REQ-013 rsp_id  output  IDW  index of requester that produced rsp_data.
REQ-014 rsp_ovf  output  1  overflow/saturation flag for rsp_data.
REQ-015 ovf_clr  input  1  synchronous clear of ovf_count.
REQ-016 ovf_count  output  16  number of saturated results accepted into the result register.

Function
REQ-017 A single shared saturating adder SHALL serve all requesters; one operation per cycle maximum.
REQ-018 Transfer on lane k SHALL occur when req_valid[k] and req_ready[k] are both high at a rising edge.
REQ-019 req_ready[k] SHALL be high only when k is the round-robin grant winner and (rsp_valid==0 or rsp_ready==1).
REQ-020 req_ready SHALL be combinational from req_valid, pointer, rsp_valid and rsp_ready; req_ready SHALL NOT depend on req_a/req_b.
REQ-021 Arbitration: search starts at pointer ptr and proceeds ptr, ptr+1, ... modulo NREQ; first lane with req_valid high wins.
REQ-022 ptr SHALL become (winner+1) mod NREQ only on a completed transfer; otherwise ptr holds.
REQ-023 Grant SHALL be withheld (all req_ready low) while rsp_valid==1 and rsp_ready==0; ptr and the result register hold.
REQ-024 Sum: full = sign-extended A + B in WIDTH+1 bits; overflow when A and B have equal sign and full[WIDTH-1] differs from that sign.
REQ-025 On overflow the result SHALL saturate to most-negative (0x8000 at WIDTH=16) if A is negative, else most-positive (0x7FFF); otherwise full[WIDTH-1:0].
REQ-026 Latency: result, ID and flag SHALL appear in rsp_data/rsp_id/rsp_ovf with rsp_valid=1 in the cycle after the transfer (1-cycle registered).
REQ-027 rsp_valid SHALL clear after rsp_ready handshake unless a new transfer occurs in the same cycle, in which case it stays 1 with new contents (full throughput, one result per cycle).
REQ-028 rsp_data/rsp_id/rsp_ovf SHALL remain stable while rsp_valid==1 and rsp_ready==0.
REQ-029 ovf_count SHALL increment by 1 on each transfer whose result overflows, saturating at 0xFFFF (no wrap).
REQ-030 ovf_clr SHALL set ovf_count to 0 and takes priority over a simultaneous increment.
REQ-031 No requester may starve: with all lanes continuously valid and rsp_ready=1, grants SHALL cycle 0,1,2,3,0,...

Reset
REQ-032 On rst_n low, immediately and asynchronously: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, ovf_count=0, ptr=0.
REQ-033 While rst_n is low, req_ready SHALL be all zero; a result in flight at reset assertion SHALL be discarded.
REQ-034 First grant after rst_n deassertion SHALL search from lane 0.

Verification
REQ-035 Single lane: lane 2 presents A=0x1234, B=0x0001, rsp_ready=1 -> next cycle rsp_data=0x1235, rsp_id=2, rsp_ovf=0, ovf_count unchanged.
REQ-036 Saturation: A=0x7FFF,B=0x0001 -> rsp_data=0x7FFF, rsp_ovf=1; A=0x8000,B=0xFFFF -> rsp_data=0x8000, rsp_ovf=1; ovf_count=2.
REQ-037 Fairness: all four lanes valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 with rsp_valid high every cycle after the first.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles with lanes valid -> req_ready all 0, rsp_data/rsp_id stable, ptr unchanged; release -> arbitration resumes at held pointer.
REQ-039 Counter edges: force 65535 overflows then one more -> ovf_count=0xFFFF; ovf_clr asserted in same cycle as an overflow -> ovf_count=0.
REQ-040 Reset mid-stream: assert rst_n low while rsp_valid=1 -> outputs zero at once; after release, lanes 3 and 0 valid -> lane 0 granted first.

Source files
------------

// File: rtl/sat_add_arbiter.sv
// rtl/sat_add_arbiter.sv - round-robin arbiter feeding one shared saturating adder
// One registered result slot; per-lane grants, saturation flag and overflow counter.
module sat_add_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_ovf,
    input  logic                  ovf_clr,
    output logic [15:0]           ovf_count
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [15:0]      ovf_count_q, ovf_count_d;

    logic             found;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   win_idx;
    logic             can_accept;
    logic             transfer;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   full;
    logic             ovf;
    logic [WIDTH-1:0] sum;

    // Search starts at the pointer and wraps; first valid lane wins.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    assign transfer   = found && can_accept;
    assign req_ready  = (transfer && rst_n) ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        op_a = req_a[win_idx*WIDTH +: WIDTH];
        op_b = req_b[win_idx*WIDTH +: WIDTH];
        full = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
        // Sign of the (WIDTH+1)-bit sum disagreeing with bit WIDTH-1 means same-sign overflow.
        ovf  = full[WIDTH] != full[WIDTH-1];
        sum  = ovf ? (op_a[WIDTH-1] ? MAX_NEG : MAX_POS) : full[WIDTH-1:0];
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_ovf_d   = rsp_ovf_q;
        if (transfer) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sum;
            rsp_id_d    = win_idx;
            rsp_ovf_d   = ovf;
            ptr_d       = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr) begin
            ovf_count_d = '0;
        end else if (transfer && ovf && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_ovf_q   <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ovf_q   <= rsp_ovf_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// tb/tb_sat_add_arbiter.sv - directed self-checking bench for sat_add_arbiter
module tb_sat_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;
    logic        ovf_clr = 1'b0;
    logic [15:0] ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    sat_add_arbiter #(.WIDTH(16), .NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf),
        .ovf_clr(ovf_clr), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        rst_n = 1'b0;
        #2;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_data !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        n_checks++; if (rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_id_ovf: got %0d/%b expected 0/0", rsp_id, rsp_ovf); end
        n_checks++; if (ovf_count !== 16'h0) begin n_fail++; $display("FAIL reset_ovf_count: got %h expected 0", ovf_count); end
        req_valid = 4'h0;
        do_reset();
    endtask

    task automatic test_single_lane();
        req_a[2*16 +: 16] = 16'h1234;
        req_b[2*16 +: 16] = 16'h0001;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b expected 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h1235) begin n_fail++; $display("FAIL single_data: got v=%b %h expected v=1 1235", rsp_valid, rsp_data); end
        n_checks++; if (rsp_id !== 2'd2 || rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL single_id_ovf: got %0d/%b expected 2/0", rsp_id, rsp_ovf); end
        n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL single_count: got %h expected 0", ovf_count); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_saturation();
        logic [15:0] va [5] = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF};
        logic [15:0] vb [5] = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h8000};
        logic [15:0] vs [5] = '{16'h7FFF, 16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF};
        logic        vo [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] vc [5] = '{16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            req_a[15:0] = va[i];
            req_b[15:0] = vb[i];
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== vs[i] || rsp_ovf !== vo[i] || rsp_id !== 2'd0) begin
                n_fail++; $display("FAIL sat_vec%0d: got v=%b %h ovf=%b id=%0d expected v=1 %h ovf=%b id=0", i, rsp_valid, rsp_data, rsp_ovf, rsp_id, vs[i], vo[i]);
            end
            n_checks++; if (ovf_count !== vc[i]) begin n_fail++; $display("FAIL sat_count%0d: got %0d expected %0d", i, ovf_count, vc[i]); end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_a[k*16 +: 16] = 16'(k << 8);
            req_b[k*16 +: 16] = 16'(k);
        end
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int j = 0; j < 6; j++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(j % 4) || rsp_data !== 16'((j % 4) * 16'h0101)) begin
                n_fail++; $display("FAIL fair_step%0d: got v=%b id=%0d %h expected v=1 id=%0d %h", j, rsp_valid, rsp_id, rsp_data, j % 4, (j % 4) * 16'h0101);
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_ready_now: got %b expected 0000", req_ready); end
        for (int j = 0; j < 5; j++) begin
            tick();
            n_checks++; if (req_ready !== 4'h0 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h0101) begin
                n_fail++; $display("FAIL bp_hold%0d: got rdy=%b v=%b id=%0d %h expected rdy=0000 v=1 id=1 0101", j, req_ready, rsp_valid, rsp_id, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_resume_ready: got %b expected 0100", req_ready); end
        tick();
        n_checks++; if (rsp_id !== 2'd2 || rsp_data !== 16'h0202) begin n_fail++; $display("FAIL bp_resume1: got id=%0d %h expected id=2 0202", rsp_id, rsp_data); end
        tick();
        n_checks++; if (rsp_id !== 2'd3 || rsp_data !== 16'h0303) begin n_fail++; $display("FAIL bp_resume2: got id=%0d %h expected id=3 0303", rsp_id, rsp_data); end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_counter_edges();
        do_reset();
        req_a[15:0] = 16'h7FFF;
        req_b[15:0] = 16'h7FFF;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (65535) tick();
        n_checks++; if (ovf_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_full: got %h expected ffff", ovf_count); end
        n_checks++; if (rsp_data !== 16'h7FFF || rsp_ovf !== 1'b1) begin n_fail++; $display("FAIL cnt_data: got %h ovf=%b expected 7fff ovf=1", rsp_data, rsp_ovf); end
        tick();
        n_checks++; if (ovf_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_nowrap: got %h expected ffff", ovf_count); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++; if (ovf_count !== 16'h0) begin n_fail++; $display("FAIL cnt_clr_prio: got %h expected 0", ovf_count); end
        tick();
        n_checks++; if (ovf_count !== 16'h1) begin n_fail++; $display("FAIL cnt_after_clr: got %h expected 1", ovf_count); end
    endtask

    task automatic test_reset_mid_stream();
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_outputs: got v=%b %h id=%0d ovf=%b expected all 0", rsp_valid, rsp_data, rsp_id, rsp_ovf);
        end
        n_checks++; if (ovf_count !== 16'h0 || req_ready !== 4'h0) begin n_fail++; $display("FAIL mid_rst_cnt_rdy: got %h/%b expected 0/0000", ovf_count, req_ready); end
        req_a[15:0] = 16'h0005;
        req_b[15:0] = 16'h0006;
        req_a[3*16 +: 16] = 16'h0100;
        req_b[3*16 +: 16] = 16'h0023;
        req_valid = 4'b1001;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h000B) begin n_fail++; $display("FAIL mid_rsp0: got v=%b id=%0d %h expected v=1 id=0 000b", rsp_valid, rsp_id, rsp_data); end
        tick();
        n_checks++; if (rsp_id !== 2'd3 || rsp_data !== 16'h0123) begin n_fail++; $display("FAIL mid_rsp3: got id=%0d %h expected id=3 0123", rsp_id, rsp_data); end
        req_valid = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_saturation();
        test_fairness();
        test_backpressure();
        test_counter_edges();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
